// File: rtl/pe_array_sched.sv
// Purpose: sequences the dot-8 PE chain for SGEMM (stream passes, pipeline flush, result drain per C block).
// Latency: write strobes emerge DOT_LATENCY en-cycles after their issue; done pulses one cycle after the last drain word.
// Backpressure: feeder_valid low or writes_fifo_full high stalls STREAM issue; writes_fifo_full stalls DRAIN; FLUSH never stalls.
module pe_array_sched #(
    parameter int DOT_LATENCY = 24,
    parameter int BLOCK_LEN   = 1024,
    parameter int DRAIN_LEN   = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      workloads_num,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic             feeder_valid,
    output logic             feeder_ready,
    input  logic             writes_fifo_full,
    output logic             en,
    output logic             cache_fifo_read,
    output logic             cache_fifo_write,
    output logic             results_fifo_write,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] block_cnt
);

    // Step counter covers issues, flush cycles and drain words (all at most 1024).
    localparam int SW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [SW-1:0]    step_cnt;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] nb_lat;

    // Tag pipeline: one valid bit and one last-pass bit per in-flight issue.
    logic [DOT_LATENCY-1:0] sr_vld;
    logic [DOT_LATENCY-1:0] sr_last;

    logic issue;
    logic pipe_en;
    logic drain_en;
    logic tag_out;
    logic last_pass;
    logic unused_wl_hi;

    assign unused_wl_hi = ^workloads_num[31:CNT_W];

    // Strobes are combinational from state and the current handshake inputs, so an async reset clears them at once.
    always_comb begin
        issue              = (state == S_STREAM) && feeder_valid && !writes_fifo_full;
        pipe_en            = issue || (state == S_FLUSH);
        drain_en           = (state == S_DRAIN) && !writes_fifo_full;
        last_pass          = (pass_cnt == w_lat - CNT_W'(1));
        tag_out            = pipe_en && sr_vld[DOT_LATENCY-1];
        en                 = pipe_en || drain_en;
        feeder_ready       = issue;
        cache_fifo_read    = issue && (pass_cnt != '0);
        cache_fifo_write   = (tag_out && !sr_last[DOT_LATENCY-1]) || drain_en;
        results_fifo_write = tag_out && sr_last[DOT_LATENCY-1];
    end

    // Tag shift register advances only on pipeline en-cycles; FLUSH shifts in bubbles so it is empty on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_vld  <= '0;
            sr_last <= '0;
        end else if (pipe_en) begin
            sr_vld  <= {sr_vld[DOT_LATENCY-2:0], issue};
            sr_last <= {sr_last[DOT_LATENCY-2:0], issue && last_pass};
        end
    end

    // Job sequencer: state, pass/block/step counters, latched job sizes and registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            step_cnt  <= '0;
            pass_cnt  <= '0;
            block_cnt <= '0;
            w_lat     <= '0;
            nb_lat    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_lat     <= (workloads_num[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                                      : workloads_num[CNT_W-1:0];
                        nb_lat    <= num_blocks;
                        pass_cnt  <= '0;
                        block_cnt <= '0;
                        step_cnt  <= '0;
                        if (num_blocks == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_STREAM;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        if (step_cnt == SW'(BLOCK_LEN - 1)) begin
                            step_cnt <= '0;
                            state    <= S_FLUSH;
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (step_cnt == SW'(DOT_LATENCY - 1)) begin
                        step_cnt <= '0;
                        if (!last_pass) begin
                            pass_cnt <= pass_cnt + CNT_W'(1);
                            state    <= S_STREAM;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_en) begin
                        if (step_cnt == SW'(DRAIN_LEN - 1)) begin
                            step_cnt <= '0;
                            pass_cnt <= '0;
                            if (block_cnt == nb_lat - CNT_W'(1)) begin
                                block_cnt <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                block_cnt <= block_cnt + CNT_W'(1);
                                state     <= S_STREAM;
                            end
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_sched.sv
// Purpose: scoreboard bench for pe_array_sched with small sizes (DOT_LATENCY=4, BLOCK_LEN=8, DRAIN_LEN=8).
// Latency: expected per-en-cycle strobe records are queued at job launch and popped by a negedge monitor.
// Backpressure: feeder_valid toggling and writes_fifo_full bursts must only insert idle cycles.
module tb_pe_array_sched;

    localparam int DL = 4;
    localparam int BL = 8;
    localparam int DR = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   workloads_num;
    logic [CW-1:0] num_blocks;
    logic          feeder_valid;
    logic          feeder_ready;
    logic          writes_fifo_full;
    logic          en;
    logic          cache_fifo_read;
    logic          cache_fifo_write;
    logic          results_fifo_write;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] block_cnt;

    pe_array_sched #(
        .DOT_LATENCY(DL),
        .BLOCK_LEN  (BL),
        .DRAIN_LEN  (DR),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .workloads_num     (workloads_num),
        .num_blocks        (num_blocks),
        .feeder_valid      (feeder_valid),
        .feeder_ready      (feeder_ready),
        .writes_fifo_full  (writes_fifo_full),
        .en                (en),
        .cache_fifo_read   (cache_fifo_read),
        .cache_fifo_write  (cache_fifo_write),
        .results_fifo_write(results_fifo_write),
        .busy              (busy),
        .done              (done),
        .pass_cnt          (pass_cnt),
        .block_cnt         (block_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_idx = 0;
    bit done_seen = 1'b0;
    bit mon_on = 1'b0;
    bit tog_on = 1'b0;

    // Record: {feeder_ready, cache_fifo_read, cache_fifo_write, results_fifo_write, done, pass_cnt, block_cnt}
    logic [36:0] exp_q[$];

    function automatic logic [36:0] rec(bit fr, bit cr, bit cw, bit rw, bit dn, int p, int b);
        logic [CW-1:0] pv;
        logic [CW-1:0] bv;
        pv = CW'(p);
        bv = CW'(b);
        return {fr, cr, cw, rw, dn, pv, bv};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every en or done cycle pops one expected record; idle busy cycles must carry no strobe.
    always @(negedge clk) begin
        if (mon_on && !reset) begin
            if (en || done) begin
                logic [36:0] got;
                logic [36:0] exp;
                got = {feeder_ready, cache_fifo_read, cache_fifo_write, results_fifo_write, done,
                       pass_cnt, block_cnt};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL event_record cyc=%0d got=%h required=%h", cyc, got, exp);
                    end
                end
                if (done) begin
                    done_seen = 1'b1;
                    done_idx  = cyc - start_cyc + 1;
                end
            end else if (busy) begin
                n_vec++;
                if ({feeder_ready, cache_fifo_read, cache_fifo_write, results_fifo_write} !== 4'b0) begin
                    n_bad++;
                    $display("FAIL strobe_without_en cyc=%0d got=%b required=0000", cyc,
                             {feeder_ready, cache_fifo_read, cache_fifo_write, results_fifo_write});
                end
            end
        end
    end

    // Expected event stream for one job, written straight from the pass/flush/drain structure.
    task automatic push_job(input int w, input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int p = 0; p < w; p++) begin
                for (int k = 0; k < BL + DL; k++) begin
                    bit iss;
                    bit wr;
                    iss = (k < BL);
                    wr  = (k >= DL);
                    exp_q.push_back(rec(iss, iss && (p != 0), wr && (p != w - 1), wr && (p == w - 1),
                                        1'b0, p, b));
                end
            end
            for (int d = 0; d < DR; d++) exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, w - 1, b));
        end
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
    endtask

    task automatic start_job(input int w, input int nb);
        @(posedge clk);
        #1;
        workloads_num = w;
        num_blocks    = CW'(nb);
        start         = 1'b1;
        start_cyc     = cyc;
        done_seen     = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_idx);
        for (int i = 0; i < 600 && !done_seen; i++) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (!done_seen) begin
            n_bad++;
            $display("FAIL %s_timeout got=no_done required=done", name);
        end else if (exp_idx > 0 && done_idx != exp_idx) begin
            n_bad++;
            $display("FAIL %s_done_cycle got=%0d required=%0d", name, done_idx, exp_idx);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover got=%0d required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        logic [38:0] o;
        o = {feeder_ready, en, cache_fifo_read, cache_fifo_write, results_fifo_write, busy, done,
             pass_cnt, block_cnt};
        n_vec++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL %s got=%h required=0", name, o);
        end
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        workloads_num    = 32'd1;
        num_blocks       = '0;
        feeder_valid     = 1'b1;
        writes_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        // Case 1: single pass, single block.
        push_job(1, 1);
        start_job(1, 1);
        wait_done("case1", 22);
        check_idle_outputs("case1_idle");

        // Case 2: three passes; a start pulse while busy must be ignored.
        push_job(3, 1);
        start_job(3, 1);
        repeat (3) @(posedge clk);
        #1;
        workloads_num = 32'd1;
        num_blocks    = CW'(5);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("case2", 1 + 3 * (BL + DL) + DR + 1);

        // Case 3: feeder_valid toggling every cycle, two passes.
        push_job(2, 1);
        tog_on = 1'b1;
        fork
            begin
                while (tog_on) begin
                    @(posedge clk);
                    #1;
                    if (tog_on) feeder_valid = ~feeder_valid;
                end
            end
        join_none
        start_job(2, 1);
        wait_done("case3", 0);
        tog_on = 1'b0;
        @(posedge clk);
        #2;
        feeder_valid = 1'b1;

        // Case 4: writes_fifo_full for 5 cycles in the middle of DRAIN.
        push_job(1, 1);
        start_job(1, 1);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (cache_fifo_write) found = 1'b1;
            end
            n_vec++;
            if (!found) begin
                n_bad++;
                $display("FAIL case4_drain_start got=none required=drain");
            end
        end
        repeat (2) @(posedge clk);
        #1;
        writes_fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        writes_fifo_full = 1'b0;
        wait_done("case4", 27);

        // Case 5: two blocks, two passes each.
        push_job(2, 2);
        start_job(2, 2);
        wait_done("case5", 1 + 2 * (2 * (BL + DL) + DR) + 1);

        // Case 7: zero blocks finishes immediately.
        push_job(1, 0);
        start_job(1, 0);
        wait_done("case7", 2);

        // Case 6: async reset during FLUSH, then case 1 again.
        mon_on = 1'b0;
        start_job(1, 1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({en, feeder_ready, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL case6_in_flush got=%b required=101", {en, feeder_ready, busy});
        end
        #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("case6_async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mon_on = 1'b1;
        push_job(1, 1);
        start_job(1, 1);
        wait_done("case6_rerun", 22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
